// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the Common Data Bus request/grant signals shared between the
//   functional units and the CDB arbiter.
//
//   CDB_rts     units -> arbiter  bit i: unit i has a result ready
//   CDB_xmit    arbiter -> units  one-hot grant, bit i: unit i owns the CDB
//   grant_id    arbiter -> units  index of the granted unit, 0 when idle
//   bus_busy    arbiter -> units  high while any CDB_xmit bit is high
//   broadcasts  arbiter -> units  saturating count of completed grants
//   error       arbiter -> units  one-cycle pulse: unit held rts past release
//
//   Modports: master = arbiter side, slave = functional-unit side.
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
   parameter int NUM_UNITS = 4,
   parameter int ID_WIDTH  = 2,
   parameter int CNT_WIDTH = 16
);
   logic [NUM_UNITS-1:0] CDB_rts;
   logic [NUM_UNITS-1:0] CDB_xmit;
   logic [ID_WIDTH-1:0]  grant_id;
   logic                 bus_busy;
   logic [CNT_WIDTH-1:0] broadcasts;
   logic                 error;

   modport master (
      input  CDB_rts,
      output CDB_xmit,
      output grant_id,
      output bus_busy,
      output broadcasts,
      output error
   );

   modport slave (
      output CDB_rts,
      input  CDB_xmit,
      input  grant_id,
      input  bus_busy,
      input  broadcasts,
      input  error
   );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter for the Tomasulo Common Data Bus. Functional units
//   raise CDB_rts when a result is ready; exactly one unit at a time is
//   granted the bus through a one-hot CDB_xmit held for XMIT_CYCLES cycles,
//   followed by a one-cycle release gap in which no grant is issued. The
//   falling edge of CDB_xmit is what a unit uses to free its reservation
//   station.
//
//   Ports
//     clock   system clock, all state updates on posedge
//     reset   synchronous, active-high; overrides an active grant
//     cdb     cdb_arbiter_if.master: CDB_rts in; CDB_xmit, grant_id,
//             bus_busy, broadcasts, error out (all registered)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_UNITS   = 4,
   parameter int ID_WIDTH    = 2,
   parameter int XMIT_CYCLES = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic          clock,
   input  logic          reset,
   cdb_arbiter_if.master cdb
);

   localparam int HOLD_W = (XMIT_CYCLES > 2) ? $clog2(XMIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state_reg;
   logic [NUM_UNITS-1:0] xmit_reg;
   logic [ID_WIDTH-1:0]  grant_id_reg;
   logic [ID_WIDTH-1:0]  cur_reg;       // unit owning the bus, kept through RELEASE
   logic [ID_WIDTH-1:0]  rr_ptr_reg;
   logic                 busy_reg;
   logic [CNT_WIDTH-1:0] bcast_reg;
   logic                 error_reg;
   logic [HOLD_W-1:0]    hold_cnt_reg;

   logic [NUM_UNITS-1:0] upper_mask;
   logic [NUM_UNITS-1:0] req_upper;
   logic [ID_WIDTH-1:0]  sel_next;

   // Positions at or above rr_ptr get first pick; the rest are the wrap-around.
   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_mask
         assign upper_mask[gi] = (ID_WIDTH'(gi) >= rr_ptr_reg);
      end
   endgenerate

   // Lowest set request in the upper region wins; if that region is empty,
   // the lowest set request overall (the wrapped search) wins.
   always_comb begin
      req_upper = cdb.CDB_rts & upper_mask;
      sel_next  = '0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         if (cdb.CDB_rts[k]) sel_next = ID_WIDTH'(k);
      end
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         if (req_upper[k]) sel_next = ID_WIDTH'(k);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         xmit_reg     <= '0;
         grant_id_reg <= '0;
         cur_reg      <= '0;
         rr_ptr_reg   <= '0;
         busy_reg     <= 1'b0;
         bcast_reg    <= '0;
         error_reg    <= 1'b0;
         hold_cnt_reg <= '0;
      end else begin
         error_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|cdb.CDB_rts) begin
                  state_reg    <= GRANT;
                  cur_reg      <= sel_next;
                  xmit_reg     <= NUM_UNITS'(1) << sel_next;
                  grant_id_reg <= sel_next;
                  busy_reg     <= 1'b1;
                  hold_cnt_reg <= HOLD_W'(XMIT_CYCLES - 1);
               end
            end
            GRANT: begin
               // Requests are deliberately ignored while the bus is held.
               if (hold_cnt_reg == '0) begin
                  state_reg    <= RELEASE;
                  xmit_reg     <= '0;
                  grant_id_reg <= '0;
                  busy_reg     <= 1'b0;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg - 1'b1;
               end
            end
            RELEASE: begin
               state_reg  <= IDLE;
               rr_ptr_reg <= (cur_reg == ID_WIDTH'(NUM_UNITS - 1)) ? '0 : cur_reg + 1'b1;
               if (bcast_reg != '1) bcast_reg <= bcast_reg + 1'b1;
               // A unit that saw its xmit fall should have dropped rts by now.
               error_reg  <= |(cdb.CDB_rts & (NUM_UNITS'(1) << cur_reg));
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign cdb.CDB_xmit   = xmit_reg;
   assign cdb.grant_id   = grant_id_reg;
   assign cdb.bus_busy   = busy_reg;
   assign cdb.broadcasts = bcast_reg;
   assign cdb.error      = error_reg;

   a_xmit_onehot0: assert property (@(posedge clock) $onehot0(xmit_reg));

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Two arbiter instances: dut1 (XMIT_CYCLES=1) and dut3 (XMIT_CYCLES=3).
//   A transaction-level reference model tracks, per instance, the owner of
//   the bus, how many xmit cycles remain, whether the release gap is
//   pending, the round-robin pointer and the broadcast count.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   logic clk = 1'b0;
   logic rst1;
   logic rst3;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_UNITS(4), .ID_WIDTH(2), .CNT_WIDTH(16)) if1 ();
   cdb_arbiter_if #(.NUM_UNITS(4), .ID_WIDTH(2), .CNT_WIDTH(16)) if3 ();

   cdb_arbiter #(.NUM_UNITS(4), .ID_WIDTH(2), .XMIT_CYCLES(1), .CNT_WIDTH(16)) dut1 (
      .clock (clk),
      .reset (rst1),
      .cdb   (if1.master)
   );

   cdb_arbiter #(.NUM_UNITS(4), .ID_WIDTH(2), .XMIT_CYCLES(3), .CNT_WIDTH(16)) dut3 (
      .clock (clk),
      .reset (rst3),
      .cdb   (if3.master)
   );

   // Reference model state, index 0 -> dut1, index 1 -> dut3.
   int m_left [2];   // xmit cycles still to run for the current owner
   int m_cool [2];   // 1 while the release gap is pending
   int m_own  [2];
   int m_ptr  [2];
   int m_cnt  [2];
   bit m_err  [2];

   // Reactive unit behaviour for dut1: drop rts when xmit falls, re-raise next cycle.
   logic [3:0] prev_x;
   logic [3:0] pend;

   task automatic model_edge(input int d, input logic rst, input logic [3:0] r);
      int  xc;
      bit  found;
      xc       = (d == 0) ? 1 : 3;
      m_err[d] = 1'b0;
      if (rst) begin
         m_left[d] = 0; m_cool[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      end else if (m_left[d] > 0) begin
         m_left[d]--;
         if (m_left[d] == 0) m_cool[d] = 1;
      end else if (m_cool[d] != 0) begin
         m_cool[d] = 0;
         m_err[d]  = r[m_own[d]];
         m_ptr[d]  = (m_own[d] + 1) % 4;
         if (m_cnt[d] < 65535) m_cnt[d]++;
      end else if (r != 4'b0) begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (!found && r[(m_ptr[d] + k) % 4]) begin
               m_own[d] = (m_ptr[d] + k) % 4;
               found    = 1'b1;
            end
         end
         m_left[d] = xc;
      end
   endtask

   function automatic logic [23:0] exp_vec(input int d);
      logic [3:0] x;
      logic [1:0] g;
      logic       b;
      b = (m_left[d] > 0);
      x = b ? 4'(1 << m_own[d]) : 4'b0;
      g = b ? 2'(m_own[d]) : 2'b0;
      return {x, g, b, 16'(m_cnt[d]), m_err[d]};
   endfunction

   // One clock: model follows the edge using the inputs the DUTs sampled.
   task automatic tick();
      @(posedge clk);
      model_edge(0, rst1, if1.CDB_rts);
      model_edge(1, rst3, if3.CDB_rts);
      @(negedge clk);
   endtask

   task automatic react(input logic [3:0] part, input logic [3:0] stuck);
      logic [3:0] fell;
      logic [3:0] r;
      fell   = prev_x & ~if1.CDB_xmit;
      r      = if1.CDB_rts | (pend & part);
      r      = r & ~(fell & ~stuck);
      pend   = fell & ~stuck;
      prev_x = if1.CDB_xmit;
      if1.CDB_rts = r;
   endtask

   task automatic reset1();
      rst1 = 1'b1;
      if1.CDB_rts = 4'b0;
      tick();
      tick();
      rst1   = 1'b0;
      prev_x = 4'b0;
      pend   = 4'b0;
   endtask

   task automatic test_reset();
      rst1 = 1'b1;
      if1.CDB_rts = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (if1.CDB_xmit !== 4'b0) begin
            bad++; $display("FAIL reset_xmit cyc%0d: got %b want 0000", i, if1.CDB_xmit);
         end
         total++;
         if (if1.broadcasts !== 16'd0) begin
            bad++; $display("FAIL reset_bcast cyc%0d: got %0d want 0", i, if1.broadcasts);
         end
      end
      rst1 = 1'b0;
      tick();
      total++;
      if (if1.CDB_xmit !== 4'b0001 || if1.grant_id !== 2'd0 || if1.bus_busy !== 1'b1) begin
         bad++; $display("FAIL reset_first_grant: got xmit=%b id=%0d busy=%b want 0001/0/1",
                         if1.CDB_xmit, if1.grant_id, if1.bus_busy);
      end
      if1.CDB_rts = 4'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_single();
      reset1();
      tick(); tick();
      if1.CDB_rts = 4'b0100;
      tick();
      total++;
      if (if1.CDB_xmit !== 4'b0100 || if1.grant_id !== 2'd2 || if1.bus_busy !== 1'b1) begin
         bad++; $display("FAIL single_grant: got xmit=%b id=%0d busy=%b want 0100/2/1",
                         if1.CDB_xmit, if1.grant_id, if1.bus_busy);
      end
      if1.CDB_rts = 4'b0;
      tick();
      total++;
      if (if1.CDB_xmit !== 4'b0 || if1.bus_busy !== 1'b0 || if1.grant_id !== 2'd0) begin
         bad++; $display("FAIL single_release: got xmit=%b busy=%b id=%0d want 0000/0/0",
                         if1.CDB_xmit, if1.bus_busy, if1.grant_id);
      end
      tick();
      total++;
      if (if1.broadcasts !== 16'd1 || if1.error !== 1'b0) begin
         bad++; $display("FAIL single_count: got bcast=%0d err=%b want 1/0",
                         if1.broadcasts, if1.error);
      end
      // Pointer now sits at 3, so with everyone requesting unit 3 goes first.
      if1.CDB_rts = 4'b1111;
      tick();
      total++;
      if (if1.CDB_xmit !== 4'b1000 || if1.grant_id !== 2'd3) begin
         bad++; $display("FAIL single_rr_ptr: got xmit=%b id=%0d want 1000/3",
                         if1.CDB_xmit, if1.grant_id);
      end
      if1.CDB_rts = 4'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_contention();
      int order[$];
      int times[$];
      int errs;
      logic [3:0] rise;
      errs = 0;
      reset1();
      if1.CDB_rts = 4'b1111;
      for (int i = 0; i < 16; i++) begin
         tick();
         rise = if1.CDB_xmit & ~prev_x;
         for (int u = 0; u < 4; u++) if (rise[u]) begin order.push_back(u); times.push_back(i); end
         if (if1.error) errs++;
         react(4'b1111, 4'b0000);
      end
      total++;
      if (order.size() < 5) begin
         bad++; $display("FAIL contention_count: got %0d grants want >=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (order[i] != i % 4) begin
               bad++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, order[i], i % 4);
            end
         end
         for (int i = 1; i < 5; i++) begin
            total++;
            if (times[i] - times[i-1] != 3) begin
               bad++; $display("FAIL contention_spacing[%0d]: got %0d want 3", i, times[i] - times[i-1]);
            end
         end
      end
      total++;
      if (errs != 0) begin
         bad++; $display("FAIL contention_error: got %0d pulses want 0", errs);
      end
      if1.CDB_rts = 4'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_wrap();
      int order[$];
      int errs;
      logic [3:0] rise;
      errs = 0;
      reset1();
      if1.CDB_rts = 4'b0100;
      tick();
      if1.CDB_rts = 4'b0;
      tick(); tick();
      if1.CDB_rts = 4'b1001;
      prev_x = 4'b0;
      pend   = 4'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         rise = if1.CDB_xmit & ~prev_x;
         for (int u = 0; u < 4; u++) if (rise[u]) order.push_back(u);
         if (if1.error) errs++;
         react(4'b1001, 4'b0000);
      end
      total++;
      if (order.size() < 2) begin
         bad++; $display("FAIL wrap_count: got %0d grants want >=2", order.size());
      end else begin
         total++;
         if (order[0] != 3 || order[1] != 0) begin
            bad++; $display("FAIL wrap_order: got %0d,%0d want 3,0", order[0], order[1]);
         end
      end
      total++;
      if (errs != 0) begin
         bad++; $display("FAIL wrap_error: got %0d pulses want 0", errs);
      end
      if1.CDB_rts = 4'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_stuck();
      int order[$];
      int err_at[$];
      logic [3:0] rise;
      reset1();
      if1.CDB_rts = 4'b0010;
      tick();
      rise = if1.CDB_xmit & ~prev_x;
      for (int u = 0; u < 4; u++) if (rise[u]) order.push_back(u);
      react(4'b1100, 4'b0010);
      if1.CDB_rts = if1.CDB_rts | 4'b1100;
      for (int i = 1; i < 10; i++) begin
         tick();
         rise = if1.CDB_xmit & ~prev_x;
         for (int u = 0; u < 4; u++) if (rise[u]) order.push_back(u);
         if (if1.error) err_at.push_back(i);
         react(4'b1100, 4'b0010);
      end
      total++;
      if (err_at.size() != 1) begin
         bad++; $display("FAIL stuck_error_pulses: got %0d want 1", err_at.size());
      end else begin
         total++;
         if (err_at[0] != 2) begin
            bad++; $display("FAIL stuck_error_cycle: got %0d want 2", err_at[0]);
         end
      end
      total++;
      if (order.size() < 4) begin
         bad++; $display("FAIL stuck_count: got %0d grants want >=4", order.size());
      end else begin
         total++;
         if (order[0] != 1 || order[1] != 2 || order[2] != 3 || order[3] != 1) begin
            bad++; $display("FAIL stuck_order: got %0d,%0d,%0d,%0d want 1,2,3,1",
                            order[0], order[1], order[2], order[3]);
         end
      end
      if1.CDB_rts = 4'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid();
      rst3 = 1'b0;
      if3.CDB_rts = 4'b0100;
      tick();
      total++;
      if (if3.CDB_xmit !== 4'b0100) begin
         bad++; $display("FAIL mid_grant1: got %b want 0100", if3.CDB_xmit);
      end
      tick();
      total++;
      if (if3.CDB_xmit !== 4'b0100) begin
         bad++; $display("FAIL mid_grant2: got %b want 0100", if3.CDB_xmit);
      end
      rst3 = 1'b1;
      tick();
      total++;
      if (if3.CDB_xmit !== 4'b0 || if3.bus_busy !== 1'b0 || if3.grant_id !== 2'd0 ||
          if3.broadcasts !== 16'd0) begin
         bad++; $display("FAIL mid_reset: got xmit=%b busy=%b id=%0d bcast=%0d want 0000/0/0/0",
                         if3.CDB_xmit, if3.bus_busy, if3.grant_id, if3.broadcasts);
      end
      rst3 = 1'b0;
      if3.CDB_rts = 4'b0;
      tick();
      total++;
      if (if3.CDB_xmit !== 4'b0) begin
         bad++; $display("FAIL mid_idle: got %b want 0000", if3.CDB_xmit);
      end
      if3.CDB_rts = 4'b0011;
      tick();
      total++;
      if (if3.CDB_xmit !== 4'b0001) begin
         bad++; $display("FAIL mid_regrant: got %b want 0001", if3.CDB_xmit);
      end
      if3.CDB_rts = 4'b0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (if3.broadcasts !== 16'd1) begin
         bad++; $display("FAIL mid_bcast: got %0d want 1", if3.broadcasts);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst1 = ($urandom_range(63) == 0);
         rst3 = ($urandom_range(63) == 0);
         if1.CDB_rts = if1.CDB_rts ^ 4'($urandom_range(15) & $urandom_range(15));
         if3.CDB_rts = if3.CDB_rts ^ 4'($urandom_range(15) & $urandom_range(15));
         tick();
         total++;
         if ({if1.CDB_xmit, if1.grant_id, if1.bus_busy, if1.broadcasts, if1.error} !== exp_vec(0)) begin
            bad++; $display("FAIL random_x1 cyc%0d: got %h want %h", c,
                            {if1.CDB_xmit, if1.grant_id, if1.bus_busy, if1.broadcasts, if1.error},
                            exp_vec(0));
         end
         total++;
         if ({if3.CDB_xmit, if3.grant_id, if3.bus_busy, if3.broadcasts, if3.error} !== exp_vec(1)) begin
            bad++; $display("FAIL random_x3 cyc%0d: got %h want %h", c,
                            {if3.CDB_xmit, if3.grant_id, if3.bus_busy, if3.broadcasts, if3.error},
                            exp_vec(1));
         end
      end
   endtask

   initial begin
      rst1 = 1'b1;
      rst3 = 1'b1;
      if1.CDB_rts = 4'b0;
      if3.CDB_rts = 4'b0;
      prev_x = 4'b0;
      pend   = 4'b0;
      for (int d = 0; d < 2; d++) begin
         m_left[d] = 0; m_cool[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0;
      end
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_stuck();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
